regfile_wb_arbiter: RTL

Write-back controller for the core's 32×32 register file. Shares the file's single write port (`w_enable`/`rd_num`/`rd_data`) among several write-back requesters via valid/ready handshakes, and keeps a pending-write scoreboard that tells issue logic when a source or destination register is not yet safe to use. It sits between the execution units and `regfile`, driving the write port directly.

---
 rtl/core_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared core constants (data width, register index width, file size)
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;
   localparam int NREG = 32;

   localparam logic [REGW-1:0] ZERO_REG = '0;

endpackage : core_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : one-hot grant to the first asserted request, searching upward
//              from i_ptr and wrapping (i_ptr = 0 gives fixed priority)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt
);

   logic w_found;
   int   w_dist;

   // k walks the priority order; requester j sits at distance (j - ptr) mod NREQ
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_dist  = 0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            w_dist = j - int'(i_ptr);
            if (w_dist < 0) begin
               w_dist = w_dist + NREQ;
            end
            if (!w_found && (w_dist == k) && i_req[j]) begin
               o_gnt[j] = 1'b1;
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : shares the register file write port among NREQ
//                      write-back requesters and tracks pending writes.
// Config macro       : WB_ROUND_ROBIN_EN (defined = round-robin, else fixed
//                      priority with requester 0 highest)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = core_pkg::XLEN,
   parameter int REGW = core_pkg::REGW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*REGW-1:0] req_rd_num,
   input  logic [NREQ*XLEN-1:0] req_rd_data,
   input  logic                 issue_valid,
   input  logic [REGW-1:0]      issue_rd,
   input  logic [REGW-1:0]      rs1_num,
   input  logic [REGW-1:0]      rs2_num,
   output logic                 rs1_busy,
   output logic                 rs2_busy,
   output logic                 rd_busy,
   output logic                 w_enable,
   output logic [REGW-1:0]      rd_num,
   output logic [XLEN-1:0]      rd_data
);

   import core_pkg::*;

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] w_req;
   logic [NREQ-1:0] w_gnt;
   logic [PW-1:0]   w_ptr;
   logic            w_xfer;
   logic [REGW-1:0] w_win_rd;
   logic [XLEN-1:0] w_win_data;

   logic            r_wen;
   logic [REGW-1:0] r_rd_num;
   logic [XLEN-1:0] r_rd_data;
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;

   // Nothing may be granted while reset is held
   assign w_req     = req_valid & {NREQ{rst}};
   assign req_ready = w_gnt;
   assign w_xfer    = |w_gnt;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req (w_req),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt)
   );

`ifdef WB_ROUND_ROBIN_EN
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_gnt_idx;

   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_gnt_idx = PW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   always_comb begin
      w_win_rd   = '0;
      w_win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_win_rd   = req_rd_num[i*REGW +: REGW];
            w_win_data = req_rd_data[i*XLEN +: XLEN];
         end
      end
   end

   // x0 writes are consumed here but never reach the write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wen     <= 1'b0;
         r_rd_num  <= '0;
         r_rd_data <= '0;
      end else if (w_xfer) begin
         r_wen     <= (w_win_rd != REGW'(ZERO_REG));
         r_rd_num  <= w_win_rd;
         r_rd_data <= w_win_data;
      end else begin
         r_wen     <= 1'b0;
      end
   end

   assign w_enable = r_wen;
   assign rd_num   = r_rd_num;
   assign rd_data  = r_rd_data;

   // Set is applied after clear so a same-index issue outlives the write-back
   assign w_set = (issue_valid && (issue_rd != REGW'(ZERO_REG))) ? (NREG'(1) << issue_rd) : '0;
   assign w_clr = w_xfer ? (NREG'(1) << w_win_rd) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
      end
   end

   assign rs1_busy = r_busy[rs1_num] |
                     (r_wen && (r_rd_num == rs1_num) && (rs1_num != REGW'(ZERO_REG)));
   assign rs2_busy = r_busy[rs2_num] |
                     (r_wen && (r_rd_num == rs2_num) && (rs2_num != REGW'(ZERO_REG)));
   assign rd_busy  = r_busy[issue_rd] |
                     (r_wen && (r_rd_num == issue_rd) && (issue_rd != REGW'(ZERO_REG)));

endmodule : regfile_wb_arbiter

`default_nettype wire
